// File: rtl/pc_fetch_unit_if.sv
// Bundles the fetch unit's npc, instruction-memory and decode-side signals.
// master = fetch unit view; slave = surrounding pipeline/memory view.
interface pc_fetch_unit_if;
   logic [31:0] npc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] instr_o;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic        stall_i;
   logic [31:0] pc_o;
   logic        fetch_err_o;
   logic [31:0] fetch_cnt_o;

   modport master (
      input  npc_i, imem_ack_i, imem_rdata_i, instr_ready_i, stall_i,
      output imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_o, fetch_err_o, fetch_cnt_o
   );

   modport slave (
      output npc_i, imem_ack_i, imem_rdata_i, instr_ready_i, stall_i,
      input  imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_o, fetch_err_o, fetch_cnt_o
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register + single-outstanding instruction fetch; ack->valid 1 cycle, 3 cycles/instr, holds on !ready or stall.
// PC_FETCH_CNT_EN adds a consumed-instruction counter on fetch_cnt_o (tied to 0 otherwise).
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   pc_fetch_unit_if.master  bus
);
   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        vld_q, vld_d;
   logic        req_q, req_d;
   logic        err_q, err_d;
   logic [7:0]  to_q, to_d;
   logic        consume;

   assign consume = (state_q == ST_EXEC) && vld_q && bus.instr_ready_i && !bus.stall_i;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      vld_d   = vld_q;
      req_d   = req_q;
      err_d   = err_q;
      to_d    = to_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
         end
         ST_FETCH: begin
            // Entering FETCH from EXEC leaves req low for one cycle while the new PC settles.
            if (!req_q) begin
               req_d = 1'b1;
            end else if (bus.imem_ack_i) begin
               instr_d = bus.imem_rdata_i;
               vld_d   = 1'b1;
               req_d   = 1'b0;
               to_d    = 8'd0;
               state_d = ST_EXEC;
            end else if (to_q == TO_LAST) begin
               err_d   = 1'b1;
               req_d   = 1'b0;
               state_d = ST_ERR;
            end else begin
               to_d = to_q + 8'd1;
            end
         end
         ST_EXEC: begin
            if (consume) begin
               pc_d    = bus.npc_i;
               vld_d   = 1'b0;
               state_d = ST_FETCH;
            end
         end
         ST_ERR: begin
            req_d = 1'b0;
            vld_d = 1'b0;
            err_d = 1'b1;
         end
         default: begin
            state_d = ST_BOOT;
            req_d   = 1'b0;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         vld_q   <= 1'b0;
         req_q   <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         vld_q   <= vld_d;
         req_q   <= req_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

`ifdef PC_FETCH_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (consume) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 32'h0;
      else        cnt_q <= cnt_d;
   end

   assign bus.fetch_cnt_o = cnt_q;
`else
   assign bus.fetch_cnt_o = 32'h0;
`endif

   assign bus.pc_o          = pc_q;
   assign bus.imem_addr_o   = pc_q;
   assign bus.imem_req_o    = req_q;
   assign bus.instr_o       = instr_q;
   assign bus.instr_valid_o = vld_q;
   assign bus.fetch_err_o   = err_q;
endmodule
